// File: rtl/led_flicker_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : led_flicker_ctrl_if
// Description : Pattern request in, LED gate / win status / step out.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_flicker_ctrl_if;
   logic [1:0] mode_req;
   logic       flicker_on;
   logic       win_done;
   logic [2:0] phase;

   modport master (
      output mode_req,
      input  flicker_on,
      input  win_done,
      input  phase
   );

   modport slave (
      input  mode_req,
      output flicker_on,
      output win_done,
      output phase
   );
endinterface
`default_nettype wire

// File: rtl/led_flicker_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_flicker_ctrl
// Description : LED flicker sequencer (cursor blink, win blink, warn burst).
// Revision    : 1.0 - initial release
// ============================================================================
module led_flicker_ctrl #(
   parameter int         WIN_TOGGLES  = 6,
   parameter logic [7:0] WARN_PATTERN = 8'b0001_0101
) (
   input  wire logic          led_flicker_clk_rst,
   input  wire logic          led_flicker_clk_slow,
   input  wire logic          led_flicker_clk_fast,
   led_flicker_ctrl_if.slave  bus
);

   localparam int                    c_WCNT_W      = $clog2(WIN_TOGGLES + 1);
   localparam logic [c_WCNT_W-1:0]   c_WIN_MAX     = c_WCNT_W'(WIN_TOGGLES);
   localparam logic [c_WCNT_W-1:0]   c_WIN_ONE     = c_WCNT_W'(1);
   localparam logic [1:0]            c_MODE_OFF    = 2'd0;
   localparam logic [1:0]            c_MODE_CURSOR = 2'd1;
   localparam logic [1:0]            c_MODE_WIN    = 2'd2;
   localparam logic [1:0]            c_MODE_WARN   = 2'd3;

   logic [1:0]          r_mode;
   logic                r_t_f;
   logic [2:0]          r_s_cnt;
   logic [c_WCNT_W-1:0] r_w_cnt;

   logic                w_win_sat;
   logic [c_WCNT_W+2:0] w_w_ext;
   logic                w_flicker_on;
   logic                w_win_done;
   logic [2:0]          w_phase;

   // The restart pulse doubles as the mode-capture clock; mode survives between pulses.
   always_ff @(posedge led_flicker_clk_rst) begin
      r_mode <= bus.mode_req;
   end

   // Fast domain: cursor toggle and warn step counter (both run; the mux picks).
   always_ff @(posedge led_flicker_clk_fast or posedge led_flicker_clk_rst) begin
      if (led_flicker_clk_rst) begin
         r_t_f   <= 1'b0;
         r_s_cnt <= 3'd0;
      end else begin
         r_t_f   <= ~r_t_f;
         r_s_cnt <= r_s_cnt + 3'd1;
      end
   end

   // Slow domain: win toggle counter, saturating at WIN_TOGGLES.
   always_ff @(posedge led_flicker_clk_slow or posedge led_flicker_clk_rst) begin
      if (led_flicker_clk_rst) begin
         r_w_cnt <= '0;
      end else if (!w_win_sat) begin
         r_w_cnt <= r_w_cnt + c_WIN_ONE;
      end
   end

   assign w_win_sat = (r_w_cnt >= c_WIN_MAX);
   assign w_w_ext   = {3'b000, r_w_cnt};

   // Output mux; warn pattern bits are the LED state directly (1 = lit).
   always_comb begin
      w_flicker_on = 1'b0;
      w_win_done   = 1'b0;
      w_phase      = 3'd0;
      case (r_mode)
         c_MODE_CURSOR: begin
            w_flicker_on = ~r_t_f;
            w_phase      = {2'b00, r_t_f};
         end
         c_MODE_WIN: begin
            w_flicker_on = w_win_sat ? 1'b1 : ~r_w_cnt[0];
            w_win_done   = (r_w_cnt == c_WIN_MAX);
            w_phase      = w_w_ext[2:0];
         end
         c_MODE_WARN: begin
            w_flicker_on = WARN_PATTERN[r_s_cnt];
            w_phase      = r_s_cnt;
         end
         c_MODE_OFF: begin
            w_flicker_on = 1'b0;
         end
         default: begin
            w_flicker_on = 1'b0;
         end
      endcase
   end

   assign bus.flicker_on = w_flicker_on;
   assign bus.win_done   = w_win_done;
   assign bus.phase      = w_phase;

endmodule
`default_nettype wire

// File: tb/tb_led_flicker_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_flicker_ctrl
// Description : Self-checking bench: vector table, corner sequences, random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_flicker_ctrl;

   localparam int         WIN_T = 6;
   localparam logic [7:0] WARN  = 8'b0001_0101;

   logic rst_clk  = 1'b0;
   logic clk_slow = 1'b0;
   logic clk_fast = 1'b0;

   led_flicker_ctrl_if bus ();

   led_flicker_ctrl #(
      .WIN_TOGGLES  (WIN_T),
      .WARN_PATTERN (WARN)
   ) dut (
      .led_flicker_clk_rst  (rst_clk),
      .led_flicker_clk_slow (clk_slow),
      .led_flicker_clk_fast (clk_fast),
      .bus                  (bus.slave)
   );

   int tests    = 0;
   int failures = 0;

   // Reference state: mode latched at last restart and edges seen since then.
   int m_mode = 0;
   int m_nf   = 0;
   int m_ns   = 0;

   typedef struct {
      logic [1:0] mode;
      int         nf;
      int         ns;
      logic       ef;
      logic       ed;
      logic [2:0] ep;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic ef, input logic ed, input logic [2:0] ep);
      tests++;
      if (bus.flicker_on !== ef || bus.win_done !== ed || bus.phase !== ep) begin
         failures++;
         $display("FAIL %s: got on=%b done=%b phase=%0d, want on=%b done=%b phase=%0d",
                  name, bus.flicker_on, bus.win_done, bus.phase, ef, ed, ep);
      end
   endtask

   task automatic model_check(input string name);
      logic       ef, ed;
      logic [2:0] ep;
      int         k;
      ef = 1'b0; ed = 1'b0; ep = 3'd0;
      case (m_mode)
         1: begin
            ef = ((m_nf % 2) == 0);
            ep = 3'(m_nf % 2);
         end
         2: begin
            k  = (m_ns < WIN_T) ? m_ns : WIN_T;
            ef = (k < WIN_T) ? ((k % 2) == 0) : 1'b1;
            ed = (k == WIN_T);
            ep = 3'(k % 8);
         end
         3: begin
            ef = ((WARN >> (m_nf % 8)) & 8'd1) != 8'd0;
            ep = 3'(m_nf % 8);
         end
         default: ;
      endcase
      check(name, ef, ed, ep);
   endtask

   task automatic restart_hi(input int m);
      bus.mode_req = 2'(m);
      #2 rst_clk = 1'b1;
      m_mode = m; m_nf = 0; m_ns = 0;
      #2;
   endtask

   task automatic restart_lo();
      rst_clk = 1'b0;
      #2;
   endtask

   task automatic restart(input int m);
      restart_hi(m);
      restart_lo();
   endtask

   task automatic fast_edge();
      #3 clk_fast = 1'b1;
      m_nf++;
      #3 clk_fast = 1'b0;
      #1;
   endtask

   task automatic slow_edge();
      #3 clk_slow = 1'b1;
      m_ns++;
      #3 clk_slow = 1'b0;
      #1;
   endtask

   initial begin
      bus.mode_req = 2'd0;
      #5;

      // Table-driven: restart, apply edges, compare with hand-derived outputs.
      vecs[0]  = '{2'd1, 0, 0, 1'b1, 1'b0, 3'd0};
      vecs[1]  = '{2'd1, 3, 0, 1'b0, 1'b0, 3'd1};
      vecs[2]  = '{2'd1, 6, 0, 1'b1, 1'b0, 3'd0};
      vecs[3]  = '{2'd2, 0, 0, 1'b1, 1'b0, 3'd0};
      vecs[4]  = '{2'd2, 0, 3, 1'b0, 1'b0, 3'd3};
      vecs[5]  = '{2'd2, 0, 6, 1'b1, 1'b1, 3'd6};
      vecs[6]  = '{2'd2, 0, 9, 1'b1, 1'b1, 3'd6};
      vecs[7]  = '{2'd3, 0, 0, 1'b1, 1'b0, 3'd0};
      vecs[8]  = '{2'd3, 3, 0, 1'b0, 1'b0, 3'd3};
      vecs[9]  = '{2'd3, 4, 0, 1'b1, 1'b0, 3'd4};
      vecs[10] = '{2'd3, 6, 0, 1'b0, 1'b0, 3'd6};
      vecs[11] = '{2'd3, 9, 0, 1'b0, 1'b0, 3'd1};
      vecs[12] = '{2'd3, 10, 0, 1'b1, 1'b0, 3'd2};
      vecs[13] = '{2'd0, 5, 5, 1'b0, 1'b0, 3'd0};
      vecs[14] = '{2'd2, 4, 2, 1'b1, 1'b0, 3'd2};
      vecs[15] = '{2'd1, 3, 4, 1'b0, 1'b0, 3'd1};
      for (int i = 0; i < 16; i++) begin
         restart(int'(vecs[i].mode));
         for (int j = 0; j < vecs[i].nf; j++) fast_edge();
         for (int j = 0; j < vecs[i].ns; j++) slow_edge();
         check($sformatf("vec%0d", i), vecs[i].ef, vecs[i].ed, vecs[i].ep);
      end

      // Full sequences, every step checked.
      restart(1);
      model_check("cursor_init");
      for (int i = 0; i < 6; i++) begin fast_edge(); model_check("cursor_seq"); end
      restart(2);
      model_check("win_init");
      for (int i = 0; i < 8; i++) begin slow_edge(); model_check("win_seq"); end
      restart(3);
      model_check("warn_init");
      for (int i = 0; i < 16; i++) begin fast_edge(); model_check("warn_seq"); end

      // Warn at step 5, restart into cursor.
      restart(3);
      for (int i = 0; i < 5; i++) fast_edge();
      check("warn_at5", 1'b0, 1'b0, 3'd5);
      restart_hi(1);
      check("restart_in_pulse", 1'b1, 1'b0, 3'd0);
      restart_lo();
      fast_edge();
      check("restart_next_fast", 1'b0, 1'b0, 3'd1);

      // Win at 3, slow edge lands while the pulse is high and must be ignored.
      restart(2);
      for (int i = 0; i < 3; i++) slow_edge();
      check("win_at3", 1'b0, 1'b0, 3'd3);
      restart_hi(2);
      clk_slow = 1'b1;
      #1 check("slow_in_pulse", 1'b1, 1'b0, 3'd0);
      clk_slow = 1'b0;
      #1;
      restart_lo();
      check("after_release", 1'b1, 1'b0, 3'd0);
      slow_edge();
      check("win_restarted", 1'b0, 1'b0, 3'd1);

      // Off mode with both flicker clocks running.
      restart(0);
      for (int i = 0; i < 20; i++) begin
         fast_edge();
         slow_edge();
         check("off_mode", 1'b0, 1'b0, 3'd0);
      end

      // Random restarts and edges against the reference.
      restart(int'($urandom_range(1, 3)));
      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r == 0)      restart(int'($urandom_range(0, 3)));
         else if (r < 6)  fast_edge();
         else             slow_edge();
         model_check("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
`default_nettype wire
